// File: rtl/fetch.sv
// Instruction-fetch stage: issues sequential word fetches over a req/gnt + rdval
// handshake, queues returned words in order and applies decode/execute redirects.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        AnyStall,
  input  logic        Jump_IDM1,
  input  logic [25:0] JumpTgt_IDM1,
  input  logic        ExRedirect_EX,
  input  logic [31:0] ExRedirectPc_EX,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRdVal,
  input  logic [31:0] IMemRdData,
  output logic [31:0] Pc_IF,
  output logic [31:0] FetchData_IF,
  output logic        InstrVal_IF
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t        entries [BUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] qcount;
  logic [OW-1:0] outst;
  logic [OW-1:0] drop;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;

  logic          grant;
  logic          push;
  logic          pop;
  logic          jump;
  logic          redirect;
  logic [31:0]   in_use;
  logic [31:0]   next_seq_pc;
  logic [31:0]   jump_tgt;
  logic [31:0]   tgt;
  logic [OW-1:0] outst_next;

  assign Pc_IF        = entries[rd_ptr].pc;
  assign FetchData_IF = entries[rd_ptr].data;
  assign InstrVal_IF  = (qcount != '0);
  assign IMemAddr     = fetch_pc;

  // Credit check counts queued words plus words still in flight, so a return
  // always has a free slot even when decode is stalled.
  assign in_use  = 32'(qcount) + 32'(outst);
  assign IMemReq = !reset && (in_use < 32'(BUF_DEPTH)) && (32'(outst) < 32'(MAX_OUTST));
  assign grant   = IMemReq && IMemGnt;

  assign outst_next = outst + OW'(grant) - OW'(IMemRdVal);

  assign pop  = InstrVal_IF && !AnyStall;
  assign jump = Jump_IDM1 && pop;

  // J/JAL keeps the region bits of the delay-slot-free successor PC.
  assign next_seq_pc = Pc_IF + 32'd4;
  assign jump_tgt    = (next_seq_pc & 32'hF000_0000) | {4'b0000, JumpTgt_IDM1, 2'b00};

  always_comb begin
    // NOTE: defaults are assigned first so every path drives both outputs and no latch is inferred.
    redirect = 1'b0;
    tgt      = fetch_pc;
    if (ExRedirect_EX) begin
      redirect = 1'b1;
      tgt      = ExRedirectPc_EX & ~32'h3;
    end else if (jump) begin
      redirect = 1'b1;
      tgt      = jump_tgt;
    end
  end

  // A word returning in a redirect cycle belongs to the killed path.
  assign push = IMemRdVal && (drop == '0) && !redirect;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      qcount   <= '0;
      outst    <= '0;
      drop     <= '0;
      // NOTE: the queue storage is reset too, because the head slot drives Pc_IF/FetchData_IF out of reset.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        entries[i] <= '{pc: RESET_PC, data: '0};
      end
    end else begin
      outst <= outst_next;
      if (redirect) begin
        fetch_pc <= tgt;
        resp_pc  <= tgt;
        drop     <= outst_next;
        rd_ptr   <= wr_ptr;
        qcount   <= '0;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (IMemRdVal && (drop != '0)) begin
          drop <= drop - OW'(1);
        end
        if (push) begin
          entries[wr_ptr] <= '{pc: resp_pc, data: IMemRdData};
          wr_ptr          <= wr_ptr + PW'(1);
          resp_pc         <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        qcount <= qcount + CW'(push) - CW'(pop);
      end
    end
  end

  push_into_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (qcount == CW'(BUF_DEPTH))));

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: in-order variable-latency memory plus a transaction-level
// reference (decode queue and in-flight list with per-request kill flags).
module tb_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;
  localparam int          MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        AnyStall;
  logic        Jump_IDM1;
  logic [25:0] JumpTgt_IDM1;
  logic        ExRedirect_EX;
  logic [31:0] ExRedirectPc_EX;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRdVal;
  logic [31:0] IMemRdData;
  logic [31:0] Pc_IF;
  logic [31:0] FetchData_IF;
  logic        InstrVal_IF;

  fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .reset(reset), .AnyStall(AnyStall), .Jump_IDM1(Jump_IDM1),
    .JumpTgt_IDM1(JumpTgt_IDM1), .ExRedirect_EX(ExRedirect_EX),
    .ExRedirectPc_EX(ExRedirectPc_EX), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemGnt(IMemGnt), .IMemRdVal(IMemRdVal), .IMemRdData(IMemRdData),
    .Pc_IF(Pc_IF), .FetchData_IF(FetchData_IF), .InstrVal_IF(InstrVal_IF)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } ientry_t;
  typedef struct { logic [31:0] addr; bit live; } fly_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  ientry_t     m_q[$];
  fly_t        m_fly[$];
  mreq_t       mem[$];
  logic [31:0] m_fetch_pc;
  bit          m_init;
  bit          m_fresh;
  int          cyc;
  int          last_due;
  int          n_assert;
  int          n_fail;

  bit          d_reset, d_stall, d_jump, d_ex;
  logic [25:0] d_jidx;
  logic [31:0] d_expc;
  int          gnt_pct, lat_min, lat_max;

  bit          o_val, o_req, o_gnt, o_rdval;
  logic [31:0] o_pc, o_data, o_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] m;
    m = a * 32'h9E37_79B1;
    return m ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: drive at negedge, compare against the reference, advance both models.
  task automatic tick();
    bit          exp_val, exp_req, grant, ret, ex, jmp;
    fly_t        r;
    logic [31:0] exp_pc, exp_data, tgt;
    int          due;
    @(negedge clk);
    reset           = d_reset;
    AnyStall        = d_stall;
    Jump_IDM1       = d_jump;
    JumpTgt_IDM1    = d_jidx;
    ExRedirect_EX   = d_ex;
    ExRedirectPc_EX = d_expc;
    IMemGnt         = ($urandom_range(0, 99) < gnt_pct);
    if (!d_reset && mem.size() > 0 && mem[0].due <= cyc) begin
      IMemRdVal  = 1'b1;
      IMemRdData = mem_word(mem[0].addr);
    end else begin
      IMemRdVal  = 1'b0;
      IMemRdData = $urandom;
    end
    #1;
    o_val = InstrVal_IF; o_req = IMemReq; o_addr = IMemAddr; o_pc = Pc_IF;
    o_data = FetchData_IF; o_gnt = IMemGnt; o_rdval = IMemRdVal;

    exp_val = m_q.size() > 0;
    exp_req = !d_reset && (m_q.size() + m_fly.size() < BUF_DEPTH) && (m_fly.size() < MAX_OUTST);
    if (m_init) begin
      n_assert++;
      if (o_val !== exp_val) begin
        n_fail++; $display("FAIL instr_val cyc %0d: got %b expected %b", cyc, o_val, exp_val);
      end
      n_assert++;
      if (o_req !== exp_req) begin
        n_fail++; $display("FAIL imem_req cyc %0d: got %b expected %b", cyc, o_req, exp_req);
      end
      n_assert++;
      if (o_addr !== m_fetch_pc) begin
        n_fail++; $display("FAIL imem_addr cyc %0d: got %h expected %h", cyc, o_addr, m_fetch_pc);
      end
      if (exp_val || m_fresh) begin
        exp_pc   = exp_val ? m_q[0].pc : RESET_PC;
        exp_data = exp_val ? m_q[0].data : 32'h0;
        n_assert++;
        if (o_pc !== exp_pc) begin
          n_fail++; $display("FAIL pc_if cyc %0d: got %h expected %h", cyc, o_pc, exp_pc);
        end
        n_assert++;
        if (o_data !== exp_data) begin
          n_fail++; $display("FAIL fetch_data cyc %0d: got %h expected %h", cyc, o_data, exp_data);
        end
      end
    end

    // Memory follows the DUT's actual handshake; responses stay in order.
    if (d_reset) begin
      mem.delete();
      last_due = -1;
    end else begin
      if (IMemRdVal) void'(mem.pop_front());
      if (IMemReq && IMemGnt) begin
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem.push_back('{addr: IMemAddr, due: due});
      end
    end

    if (d_reset) begin
      m_q.delete();
      m_fly.delete();
      m_fetch_pc = RESET_PC;
      m_init     = 1'b1;
      m_fresh    = 1'b1;
    end else if (m_init) begin
      grant = exp_req && IMemGnt;
      ret   = IMemRdVal && (m_fly.size() > 0);
      r     = '{addr: 32'h0, live: 1'b0};
      if (ret) r = m_fly.pop_front();
      if (grant) begin
        m_fly.push_back('{addr: m_fetch_pc, live: 1'b1});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      ex  = d_ex;
      jmp = d_jump && exp_val && !d_stall && !ex;
      if (ex || jmp) begin
        if (ex) tgt = d_expc & ~32'h3;
        else    tgt = ((m_q[0].pc + 32'd4) & 32'hF000_0000) | (32'(d_jidx) << 2);
        m_q.delete();
        foreach (m_fly[i]) m_fly[i].live = 1'b0;
        m_fetch_pc = tgt;
      end else begin
        if (exp_val && !d_stall) void'(m_q.pop_front());
        if (ret && r.live) begin
          m_q.push_back('{pc: r.addr, data: mem_word(r.addr)});
          m_fresh = 1'b0;
        end
      end
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic do_reset();
    d_stall = 1'b0; d_jump = 1'b0; d_ex = 1'b0; d_jidx = '0; d_expc = '0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    d_reset = 1'b1;
    tick();
    tick();
    d_reset = 1'b0;
  endtask

  task automatic wait_valid(output logic [31:0] pc, output logic [31:0] data, output bit ok);
    ok = 1'b0; pc = '0; data = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (o_val) begin
        ok = 1'b1; pc = o_pc; data = o_data;
        break;
      end
    end
  endtask

  task automatic wait_head(input logic [31:0] pc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_q.size() > 0 && m_q[0].pc == pc) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic expect_valid_pc(input string name, input logic [31:0] pc);
    logic [31:0] got_pc, got_data;
    bit ok;
    wait_valid(got_pc, got_data, ok);
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL %s: no valid head within bound, expected pc %h", name, pc);
    end else if (got_pc !== pc || got_data !== mem_word(pc)) begin
      n_fail++; $display("FAIL %s: got pc %h data %h expected pc %h data %h",
                         name, got_pc, got_data, pc, mem_word(pc));
    end
  endtask

  task automatic test_reset();
    d_stall = 1'b0; d_jump = 1'b0; d_ex = 1'b0; d_jidx = '0; d_expc = '0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    d_reset = 1'b1;
    tick();
    tick();
    n_assert++;
    if (o_req !== 1'b0 || o_val !== 1'b0 || o_pc !== RESET_PC || o_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_state: got req %b val %b pc %h data %h expected 0 0 %h 0",
                         o_req, o_val, o_pc, o_data, RESET_PC);
    end
    d_reset = 1'b0;
    tick();
    n_assert++;
    if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
      n_fail++; $display("FAIL first_req: got req %b addr %h expected 1 %h", o_req, o_addr, RESET_PC);
    end
  endtask

  task automatic test_straight_line();
    int          first_grant, first_val, n_seen;
    logic [31:0] exp_addr, exp_pc;
    do_reset();
    first_grant = -1; first_val = -1; n_seen = 0;
    exp_addr = RESET_PC; exp_pc = RESET_PC;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_req && o_gnt) begin
        if (first_grant < 0) first_grant = i;
        n_assert++;
        if (o_addr !== exp_addr) begin
          n_fail++; $display("FAIL straight_addr: got %h expected %h", o_addr, exp_addr);
        end
        exp_addr = exp_addr + 32'd4;
      end
      if (o_val) begin
        if (first_val < 0) first_val = i;
        n_seen++;
        n_assert++;
        if (o_pc !== exp_pc || o_data !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL straight_head: got pc %h data %h expected pc %h data %h",
                             o_pc, o_data, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    n_assert++;
    if (first_grant < 0 || first_val - first_grant != 2) begin
      n_fail++; $display("FAIL grant_to_valid_latency: got %0d expected 2", first_val - first_grant);
    end
    n_assert++;
    if (n_seen < 10) begin
      n_fail++; $display("FAIL straight_progress: got %0d instructions expected at least 10", n_seen);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    wait_head(32'h10, ok);
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL bp_reach_head: head 0x10 not reached within bound");
    end
    d_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_assert++;
      if (o_val !== 1'b1 || o_pc !== 32'h10 || o_data !== mem_word(32'h10)) begin
        n_fail++; $display("FAIL bp_hold: got val %b pc %h data %h expected 1 00000010 %h",
                           o_val, o_pc, o_data, mem_word(32'h10));
      end
    end
    n_assert++;
    if (o_req !== 1'b0) begin
      n_fail++; $display("FAIL bp_req_throttle: got req %b expected 0", o_req);
    end
    d_stall = 1'b0;
    expect_valid_pc("bp_release_head", 32'h10);
    expect_valid_pc("bp_resume", 32'h14);
    expect_valid_pc("bp_resume_next", 32'h18);
  endtask

  task automatic test_jump();
    bit ok;
    do_reset();
    d_ex = 1'b1; d_expc = 32'h0040_0100;
    tick();
    d_ex = 1'b0;
    wait_head(32'h0040_0100, ok);
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL jump_reach_head: head 00400100 not reached within bound");
    end
    d_jump = 1'b1; d_jidx = 26'h010_0040;
    tick();
    d_jump = 1'b0;
    tick();
    n_assert++;
    if (o_addr !== 32'h0040_0100 || o_val !== 1'b0) begin
      n_fail++; $display("FAIL jump_addr: got addr %h val %b expected 00400100 0", o_addr, o_val);
    end
    expect_valid_pc("jump_target_head", 32'h0040_0100);

    // Jump from the last word of a 256 MB region takes the next region's top bits.
    d_ex = 1'b1; d_expc = 32'h0FFF_FFFC;
    tick();
    d_ex = 1'b0;
    wait_head(32'h0FFF_FFFC, ok);
    d_jump = 1'b1; d_jidx = 26'h000_0010;
    tick();
    d_jump = 1'b0;
    tick();
    n_assert++;
    if (o_addr !== 32'h1000_0040) begin
      n_fail++; $display("FAIL jump_region_carry: got addr %h expected 10000040", o_addr);
    end
    expect_valid_pc("jump_region_head", 32'h1000_0040);
  endtask

  task automatic test_branch_vs_jump();
    bit ok;
    do_reset();
    wait_head(32'h8, ok);
    d_stall = 1'b1;
    d_ex = 1'b1; d_expc = 32'h0000_0203;
    d_jump = 1'b1; d_jidx = 26'h3FF_FFFF;
    tick();
    d_ex = 1'b0; d_jump = 1'b0; d_stall = 1'b0;
    tick();
    n_assert++;
    if (o_addr !== 32'h200 || o_val !== 1'b0) begin
      n_fail++; $display("FAIL branch_priority: got addr %h val %b expected 00000200 0", o_addr, o_val);
    end
    expect_valid_pc("branch_target_head", 32'h200);
  endtask

  task automatic test_long_latency();
    int          n_rd;
    logic [31:0] tgt;
    bit          ok;
    do_reset();
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && m_fly.size() < MAX_OUTST; i++) tick();
    tgt = 32'h8000_1000;
    d_ex = 1'b1; d_expc = tgt;
    tick();
    d_ex = 1'b0;
    n_rd = 0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (o_val) begin
        ok = 1'b1;
        break;
      end
      if (o_rdval) n_rd++;
    end
    n_assert++;
    if (!ok || o_pc !== tgt || o_data !== mem_word(tgt)) begin
      n_fail++; $display("FAIL long_lat_target: got ok %b pc %h expected pc %h", ok, o_pc, tgt);
    end
    n_assert++;
    if (n_rd - 1 != 2) begin
      n_fail++; $display("FAIL long_lat_dropped: got %0d discarded expected 2", n_rd - 1);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    lat_min = 2; lat_max = 2;
    d_stall = 1'b1;
    for (int i = 0; i < 20 && !(m_q.size() > 0 && m_fly.size() > 0); i++) tick();
    d_reset = 1'b1;
    tick();
    n_assert++;
    if (o_req !== 1'b0) begin
      n_fail++; $display("FAIL midreset_req: got %b expected 0", o_req);
    end
    tick();
    n_assert++;
    if (o_val !== 1'b0 || o_req !== 1'b0 || o_pc !== RESET_PC) begin
      n_fail++; $display("FAIL midreset_state: got val %b req %b pc %h expected 0 0 %h",
                         o_val, o_req, o_pc, RESET_PC);
    end
    d_reset = 1'b0; d_stall = 1'b0;
    tick();
    n_assert++;
    if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
      n_fail++; $display("FAIL midreset_restart: got req %b addr %h expected 1 %h", o_req, o_addr, RESET_PC);
    end
    expect_valid_pc("midreset_first_head", RESET_PC);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      gnt_pct = 70; lat_min = 1; lat_max = 4;
      d_stall = ($urandom_range(0, 99) < 30);
      d_jump  = ($urandom_range(0, 99) < 15);
      d_jidx  = 26'($urandom);
      d_ex    = ($urandom_range(0, 99) < 5);
      d_expc  = $urandom;
      d_reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    d_reset = 1'b0; d_jump = 1'b0; d_ex = 1'b0; d_stall = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; last_due = -1;
    m_init = 1'b0; m_fresh = 1'b0; m_fetch_pc = RESET_PC;
    reset = 1'b1; AnyStall = 1'b0; Jump_IDM1 = 1'b0; JumpTgt_IDM1 = '0;
    ExRedirect_EX = 1'b0; ExRedirectPc_EX = '0; IMemGnt = 1'b0;
    IMemRdVal = 1'b0; IMemRdData = '0;
    test_reset();
    test_straight_line();
    test_backpressure();
    test_jump();
    test_branch_vs_jump();
    test_long_latency();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
